// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter
//   Multi-port front end to a set of single-access memory banks. Each bank
//   arbitrates round-robin among the ports that target it. A granted request
//   performs its bank access in the same cycle and produces a registered
//   response one cycle later. No request queueing and no response
//   backpressure.
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   req_valid     per-port request valid
//   req_ready     per-port grant this cycle (combinational)
//   req_wen       per-port 1 = write, 0 = read
//   req_addr      flattened word addresses, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata     flattened write data, same packing
//   req_tag       flattened request tags, same packing
//   rsp_valid     per-port response valid, one cycle after the grant
//   rsp_data      flattened read data (zero for write responses)
//   rsp_tag       flattened tag of the request being answered
//   conflict_cnt  saturating count of cycles with any ungranted valid request
module banked_mem_arbiter #(
  parameter int NUM_PORTS   = 3,
  parameter int NUM_BANKS   = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 2,
  parameter int BANK_SEL_HI = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_wen,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_data,
  output logic [NUM_PORTS*TAG_W-1:0]  rsp_tag,
  output logic [15:0]                 conflict_cnt
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LOCAL_W   = ADDR_W - BANK_BITS;
  localparam int DEPTH     = 1 << LOCAL_W;
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [BANK_BITS-1:0] port_bank  [NUM_PORTS];
  logic [LOCAL_W-1:0]   port_local [NUM_PORTS];
  logic [DATA_W-1:0]    port_wdata [NUM_PORTS];
  logic [TAG_W-1:0]     port_tag   [NUM_PORTS];
  logic [DATA_W-1:0]    rsp_data_q [NUM_PORTS];
  logic [TAG_W-1:0]     rsp_tag_q  [NUM_PORTS];

  logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];

  logic [PTR_W-1:0]     rr_ptr   [NUM_BANKS];
  logic [PTR_W-1:0]     bank_win [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_gnt;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] valid_eff;
  logic [PTR_W-1:0]     cand;

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      logic [ADDR_W-1:0] addr_p;
      assign addr_p = req_addr[gp*ADDR_W +: ADDR_W];
      if (BANK_SEL_HI != 0) begin : g_hi
        assign port_bank[gp]  = addr_p[ADDR_W-1 -: BANK_BITS];
        assign port_local[gp] = addr_p[LOCAL_W-1:0];
      end else begin : g_lo
        assign port_bank[gp]  = addr_p[BANK_BITS-1:0];
        assign port_local[gp] = addr_p[ADDR_W-1:BANK_BITS];
      end
      assign port_wdata[gp] = req_wdata[gp*DATA_W +: DATA_W];
      assign port_tag[gp]   = req_tag[gp*TAG_W +: TAG_W];
      assign rsp_data[gp*DATA_W +: DATA_W] = rsp_data_q[gp];
      assign rsp_tag[gp*TAG_W +: TAG_W]    = rsp_tag_q[gp];
    end
  endgenerate

  // Gating valid with reset keeps ready low and blocks writes during reset.
  assign valid_eff = req_valid & {NUM_PORTS{reset_n}};
  assign req_ready = grant;

  // Scan from the farthest offset down to rr_ptr so the nearest requester
  // (in round-robin order) is the last one to claim the bank.
  always_comb begin
    grant    = '0;
    bank_gnt = '0;
    cand     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_win[b] = '0;
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
        cand = PTR_W'((int'(rr_ptr[b]) + off) % NUM_PORTS);
        if (valid_eff[cand] && (port_bank[cand] == BANK_BITS'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = cand;
        end
      end
      if (bank_gnt[b]) grant[bank_win[b]] = 1'b1;
    end
  end

  // Storage is not reset; only granted writes touch it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b] && req_wen[bank_win[b]])
        mem[b][port_local[bank_win[b]]] <= port_wdata[bank_win[b]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_data_q[p] <= '0;
        rsp_tag_q[p]  <= '0;
      end
      rsp_valid    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_gnt[b])
          rr_ptr[b] <= (int'(bank_win[b]) == NUM_PORTS - 1) ? '0 : bank_win[b] + PTR_W'(1);
      end
      rsp_valid <= grant;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[p]) begin
          rsp_tag_q[p]  <= port_tag[p];
          rsp_data_q[p] <= req_wen[p] ? '0 : mem[port_bank[p]][port_local[p]];
        end else begin
          rsp_tag_q[p]  <= '0;
          rsp_data_q[p] <= '0;
        end
      end
      if (|(req_valid & ~grant) && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_banked_mem_arbiter.sv
module tb_banked_mem_arbiter;
  localparam int NP = 3;
  localparam int NB = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic [NP-1:0]    req_valid, req_ready, req_wen, rsp_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata, rsp_data;
  logic [NP*TW-1:0] req_tag, rsp_tag;
  logic [15:0]      conflict_cnt;

  logic [NP-1:0]    lo_valid, lo_ready, lo_wen, lo_rsp_valid;
  logic [NP*AW-1:0] lo_addr;
  logic [NP*DW-1:0] lo_wdata, lo_rsp_data;
  logic [NP*TW-1:0] lo_tag, lo_rsp_tag;
  logic [15:0]      lo_conflict;

  banked_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .conflict_cnt(conflict_cnt)
  );

  banked_mem_arbiter #(.BANK_SEL_HI(0)) dut_lo (
    .clk(clk), .reset_n(reset_n),
    .req_valid(lo_valid), .req_ready(lo_ready), .req_wen(lo_wen),
    .req_addr(lo_addr), .req_wdata(lo_wdata), .req_tag(lo_tag),
    .rsp_valid(lo_rsp_valid), .rsp_data(lo_rsp_data), .rsp_tag(lo_rsp_tag),
    .conflict_cnt(lo_conflict)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          rr_m [NB];
  logic [DW-1:0] mem_m [4096];
  bit          known_m [4096];
  int          conf_m;
  bit          ev [NP];
  logic [TW-1:0] et [NP];
  logic [DW-1:0] ed [NP];
  bit          ek [NP];
  logic [NP-1:0] last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'(a[AW-1:AW-2]);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    for (int p = 0; p < NP; p++) ev[p] = 0;
    conf_m = 0;
  endtask

  task automatic set_port(input int p, input bit v, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid[p] = v;
    req_wen[p]   = w;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_tag[p*TW +: TW]   = t;
  endtask

  task automatic set_lo(input int p, input bit v, input logic [AW-1:0] a);
    lo_valid[p] = v;
    lo_wen[p]   = 1'b0;
    lo_addr[p*AW +: AW]  = a;
    lo_wdata[p*DW +: DW] = '0;
    lo_tag[p*TW +: TW]   = TW'(p);
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, '0, '0, '0);
  endtask

  // One cycle: inputs are already applied. Model picks, per bank, the valid
  // requester at the smallest round-robin distance from that bank's pointer.
  task automatic step();
    logic [NP-1:0] exp_ready;
    logic [AW-1:0] a;
    int best_p, best_d, d;
    #1;
    exp_ready = '0;
    for (int b = 0; b < NB; b++) begin
      best_p = -1;
      best_d = NP;
      for (int p = 0; p < NP; p++) begin
        a = req_addr[p*AW +: AW];
        if (req_valid[p] && bank_of(a) == b) begin
          d = (p - rr_m[b] + NP) % NP;
          if (d < best_d) begin
            best_d = d;
            best_p = p;
          end
        end
      end
      if (best_p >= 0) begin
        exp_ready[best_p] = 1'b1;
        rr_m[b] = (best_p + 1) % NP;
      end
    end
    last_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    if ((req_valid & ~exp_ready) != 0 && conf_m < 65535) conf_m++;
    for (int p = 0; p < NP; p++) begin
      ev[p] = exp_ready[p];
      if (exp_ready[p]) begin
        a = req_addr[p*AW +: AW];
        et[p] = req_tag[p*TW +: TW];
        if (req_wen[p]) begin
          ed[p] = '0;
          ek[p] = 1;
          mem_m[a] = req_wdata[p*DW +: DW];
          known_m[a] = 1;
        end else begin
          ed[p] = mem_m[a];
          ek[p] = known_m[a];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      check("rsp_valid", rsp_valid[p], ev[p]);
      if (ev[p]) begin
        check("rsp_tag", rsp_tag[p*TW +: TW], et[p]);
        if (ek[p]) check("rsp_data", rsp_data[p*DW +: DW], ed[p]);
      end
    end
    check("conflict_cnt", conflict_cnt, conf_m);
  endtask

  initial begin
    int c0;
    reset_n = 1'b0;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_tag = '0;
    lo_valid = '0; lo_wen = '0; lo_addr = '0; lo_wdata = '0; lo_tag = '0;
    last_ready = '0;
    model_reset();

    // ready must stay low in reset even with requests pending
    set_port(0, 1, 1, 12'h010, 16'h1234, 0);
    set_port(1, 1, 0, 12'h410, 16'h0, 1);
    #2;
    check("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_conflict", conflict_cnt, 0);
    check("rst_lo_conflict", lo_conflict, 0);
    idle_all();
    reset_n = 1'b1;

    // write then read-after-write on port 0
    set_port(0, 1, 1, 12'h005, 16'hBEEF, 2'd1);
    step();
    check("w_rsp_tag", rsp_tag[1:0], 1);
    check("w_rsp_data", rsp_data[15:0], 16'h0000);
    set_port(0, 1, 0, 12'h005, 16'h0, 2'd2);
    step();
    check("r_rsp_tag", rsp_tag[1:0], 2);
    check("r_rsp_data", rsp_data[15:0], 16'hBEEF);
    idle_all();
    step();

    // three ports to three banks in one cycle
    set_port(0, 1, 0, 12'h000, 16'h0, 2'd0);
    set_port(1, 1, 0, 12'h400, 16'h0, 2'd1);
    set_port(2, 1, 0, 12'h800, 16'h0, 2'd2);
    step();
    check("par_ready", last_ready, 3'b111);
    check("par_conflict", conflict_cnt, 0);
    idle_all();
    step();

    // interleaved bank select on the second instance
    set_lo(0, 1, 12'h001);
    set_lo(1, 1, 12'h005);
    #1;
    check("lo_conflict_ready", lo_ready, 3'b001);
    @(posedge clk); #1;
    check("lo_conflict_cnt1", lo_conflict, 1);
    set_lo(0, 0, 12'h001);
    #1;
    check("lo_hold_ready", lo_ready, 3'b010);
    @(posedge clk); #1;
    set_lo(0, 1, 12'h001);
    set_lo(1, 1, 12'h002);
    #1;
    check("lo_split_ready", lo_ready, 3'b011);
    @(posedge clk); #1;
    check("lo_split_rsp", lo_rsp_valid, 3'b011);
    check("lo_conflict_cnt2", lo_conflict, 1);
    set_lo(0, 0, 12'h0);
    set_lo(1, 0, 12'h0);

    // contention from reset: three ports to bank 0
    reset_n = 1'b0;
    model_reset();
    #2;
    check("rst2_conflict", conflict_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_port(0, 1, 0, 12'h001, 16'h0, 2'd0);
    set_port(1, 1, 0, 12'h002, 16'h0, 2'd1);
    set_port(2, 1, 0, 12'h003, 16'h0, 2'd2);
    step();
    check("rr_grant0", last_ready, 3'b001);
    set_port(0, 0, 0, 12'h0, 16'h0, 2'd0);
    step();
    check("rr_grant1", last_ready, 3'b010);
    set_port(1, 0, 0, 12'h0, 16'h0, 2'd0);
    step();
    check("rr_grant2", last_ready, 3'b100);
    check("rr_conflict", conflict_cnt, 2);
    idle_all();

    // random traffic; an ungranted port keeps its request unchanged
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] || last_ready[p]) begin
          set_port(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   {2'($urandom_range(0, 3)), 8'h00, 2'($urandom_range(0, 3))},
                   16'($urandom), 2'($urandom_range(0, 3)));
        end
      end
      step();
    end
    idle_all();
    step();

    // reset right after a read grant discards the response
    set_port(0, 1, 0, 12'h005, 16'h0, 2'd3);
    #1;
    check("pre_rst_ready", req_ready, 3'b001);
    @(posedge clk); #1;
    check("pre_rst_rsp", rsp_valid, 3'b001);
    idle_all();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_tag", rsp_tag, 0);
    check("midrst_conflict", conflict_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rsp_valid", rsp_valid, 0);
    set_port(0, 1, 0, 12'h001, 16'h0, 2'd0);
    set_port(1, 1, 0, 12'h002, 16'h0, 2'd1);
    set_port(2, 1, 0, 12'h003, 16'h0, 2'd2);
    step();
    check("post_rst_grant", last_ready, 3'b001);
    idle_all();
    step();

    // saturation: two ports hold requests to bank 0 every cycle
    c0 = conf_m;
    set_port(0, 1, 0, 12'h001, 16'h0, 2'd0);
    set_port(1, 1, 0, 12'h002, 16'h0, 2'd1);
    repeat (1000) @(posedge clk);
    #1;
    check("sat_partial", conflict_cnt, c0 + 1000);
    repeat (64540) @(posedge clk);
    #1;
    check("sat_value", conflict_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", conflict_cnt, 16'hFFFF);
    idle_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/banked_mem_arbiter.md
BANKED_MEM_ARBITER -- requirements
Module: banked_mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3, sets the number of request ports (1..8).
REQ-002 Parameter NUM_BANKS, default 4, sets the number of banks (power of 2, 2..16); BANK_BITS = log2(NUM_BANKS).
REQ-003 Parameter ADDR_W, default 12, sets the global word address width; bank depth = 2^(ADDR_W-BANK_BITS).
REQ-004 Parameter DATA_W, default 16, sets the data width.
REQ-005 Parameter TAG_W, default 2, sets the request tag width.
REQ-006 Parameter BANK_SEL_HI, default 1, selects the bank field: 1 = addr MSBs, 0 = addr LSBs (interleaved); the remaining bits form the bank-local address.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset_n  in  1  reset, asynchronous, active-low.
REQ-009 req_valid  in  NUM_PORTS  per-port request valid.
REQ-010 req_ready  out  NUM_PORTS  per-port request accepted this cycle (combinational).
REQ-011 req_wen  in  NUM_PORTS  1 = write, 0 = read.
REQ-012 req_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-013 req_wdata  in  NUM_PORTS*DATA_W  flattened write data, same packing.
REQ-014 req_tag  in  NUM_PORTS*TAG_W  flattened request tags, same packing.
REQ-015 rsp_valid  out  NUM_PORTS  per-port response valid (registered).
REQ-016 rsp_data  out  NUM_PORTS*DATA_W  read data; zero for write responses.
REQ-017 rsp_tag  out  NUM_PORTS*TAG_W  tag of the request being answered.
REQ-018 conflict_cnt  out  16  saturating count of cycles in which at least one valid request was not granted.

Function
REQ-019 Each bank SHALL contain an internal unreset storage array of 2^(ADDR_W-BANK_BITS) x DATA_W, with one access per cycle.
REQ-020 Each bank SHALL run a round-robin arbiter over the ports whose req_valid=1 and whose bank field selects that bank.
REQ-021 The arbiter search SHALL start at that bank's pointer rr_ptr and proceed upward modulo NUM_PORTS; the first requester found wins.
REQ-022 req_ready[p] SHALL be 1 exactly when port p wins the arbiter of its target bank in that cycle, and 0 whenever req_valid[p]=0.
REQ-023 A handshake (req_valid & req_ready) in cycle N SHALL perform the bank access in cycle N.
- Write: stores req_wdata at the bank-local address.
- Read: registers the addressed word.
REQ-024 A handshake in cycle N SHALL produce, in cycle N+1, rsp_valid[p]=1 and rsp_tag[p] = tag accepted in cycle N; rsp_data[p] carries read data for a read and 0 for a write.
REQ-025 rsp_valid[p] SHALL be 0 in any cycle not preceded by a handshake on port p; there is no response backpressure.
REQ-026 On a grant to port w, that bank's rr_ptr SHALL update to (w+1) mod NUM_PORTS; with no grant, rr_ptr holds.
REQ-027 A read handshaken in cycle N+1 to an address written in cycle N SHALL return the written data; writes and reads never share a bank in the same cycle.
REQ-028 A port whose request is not granted SHALL hold valid, addr, wdata, wen and tag stable until granted; the block does not queue requests.
REQ-029 Requests from different ports to different banks SHALL all be granted in the same cycle; up to min(NUM_PORTS, NUM_BANKS) grants per cycle.
REQ-030 conflict_cnt SHALL increment by 1 in each cycle with any (req_valid[p] & ~req_ready[p]) and SHALL saturate at 16'hFFFF.

Reset
REQ-031 While reset_n=0: all rr_ptr = 0, rsp_valid = 0, rsp_data = 0, rsp_tag = 0, conflict_cnt = 0; memory contents are undefined and not cleared.
REQ-032 req_ready SHALL be 0 while reset_n=0, and no write SHALL occur.
REQ-033 A reset asserted mid-operation SHALL discard any in-flight response (rsp_valid = 0 on the next cycle after release).

Verification
REQ-034 Default params; port0 writes 0xBEEF to 0x005, tag 1; next cycle port0 reads 0x005, tag 2 -> responses tag 1 data 0x0000, then tag 2 data 0xBEEF, one cycle after each grant.
REQ-035 Ports 0,1,2 read addrs 0x000, 0x400, 0x800 (banks 0,1,2) in the same cycle -> all req_ready=1; three responses next cycle; conflict_cnt stays 0.
REQ-036 All three ports hold reads to bank 0 for 3 cycles from reset -> grants in order p0, p1, p2; conflict_cnt = 2.
REQ-037 BANK_SEL_HI=0: addrs 0x001 and 0x005 target bank 1 -> conflict; addrs 0x001 and 0x002 -> both granted.
REQ-038 Force conflict_cnt near saturation with 65540 continuous conflict cycles -> value 0xFFFF and holds.
REQ-039 Assert reset_n low on the cycle after a read grant -> rsp_valid=0, conflict_cnt=0, rr_ptr=0 (next contention granted to p0).
